ppi_wb_hs: RTL
==============

// Module: ppi_wb_hs
// PURPOSE
// - Parametrised Wishbone parallel peripheral interface: NPORTS independent ports of DW bits.
// - Each port is input or output, with an optional 8255-style strobed handshake (STB/IBF, OBF/ACK).
// - Handshake events raise a shared interrupt.
// - Sits on the I/O Wishbone bus alongside the existing PPI; it serves peripherals that need
//   latched or acknowledged transfers.
// PARAMETERS
// NPORTS   3   number of ports (1..8)
// DW       8   port and bus data width (>=8)
// AW       $clog2(2*NPORTS)   address width (derived, not overridden)
// PORTS
// clk_i    in   1          system clock
// rst_ni   in   1          asynchronous active-low reset
// adr_i    in   AW         register address: 2p = DATA(p), 2p+1 = CTRL/STAT(p)
// dat_i    in   DW         write data
// dat_o    out  DW         read data, valid while ack_o=1
// we_i     in   1          1=write, 0=read
// cyc_i    in   1          bus cycle
// stb_i    in   1          strobe
// ack_o    out  1          single-cycle acknowledge
// irq_o    out  1          OR of all port INTR bits, registered
// pin_i    in   NPORTS*DW  port input pins, asynchronous
// pout_o   out  NPORTS*DW  port output latches
// poe_o    out  NPORTS*DW  output enables (all 1 when DIR=1)
// stb_ni   in   NPORTS     input strobe, active low, asynchronous
// ibf_o    out  NPORTS     input buffer full
// obf_no   out  NPORTS     output buffer full, active low
// ack_ni   in   NPORTS     output acknowledge, active low, asynchronous
// BEHAVIOUR
// - Reset (async, rst_ni=0):
//   - Outputs: ack_o=0, dat_o=0, irq_o=0, pout_o=0, poe_o=0, ibf_o=0, obf_no=all 1.
//   - State: all CTRL=0, all flags clear.
//   - Mid-cycle reset aborts the bus cycle; no ack is issued.
// - Bus timing:
//   - ack_o rises one cycle after cyc_i&stb_i and stays high for exactly one cycle.
//   - ack_o is never asserted on two consecutive cycles.
//   - Register writes and read side effects take effect on the ack edge.
// - Unmapped address (>=2*NPORTS): reads return 0, writes are ignored, the access is still acked.
// - CTRL bits: [0]DIR (1=out), [1]HS (handshake), [2]IE. Other bits read 0.
// - STAT read at 2p+1 returns {IE,HS,DIR} in [2:0], IBF[4], OBF[5], INTR[6], OVR[7].
// - Writing CTRL clears IBF, OBF, OVR, INTR and the output latch of that port.
// - Synchronisers: pin_i, stb_ni and ack_ni pass through 2-FF synchronisers.
//   Edges are detected on the synchronised value; pin-to-readable latency is 2 clocks.
// - Mode DIR=0, HS=0: DATA read returns the synchronised pins.
// - Mode DIR=1: poe_o=all 1; pout_o=latch; DATA read returns the latch.
// - Handshake input (DIR=0, HS=1), on a synchronised stb_ni falling edge:
//   - If IBF=0: latch the synchronised pins, IBF=1.
//   - If IBF=1: keep the old data and set OVR.
//   - A DATA read returns the latch and clears IBF.
//   - A DATA read in the same cycle as a strobe edge returns the old data; the new data is
//     latched and IBF stays 1.
//   - OVR is cleared by a STAT read.
// - Handshake output (DIR=1, HS=1):
//   - A DATA write loads the latch, sets OBF and clears INTR.
//   - A synchronised ack_ni falling edge clears OBF and sets INTR.
//   - A write while OBF=1 overwrites the latch; OBF stays 1.
//   - A write in the same cycle as an ack edge: the write wins, OBF=1, INTR=0.
// - INTR:
//   - Input handshake: INTR = IBF & IE.
//   - Output handshake: INTR is a sticky bit, and it is gated by IE.
//   - With HS=0, INTR=0.
// - irq_o updates one cycle after any INTR change.
// TESTING
// - Reset -> every output at its reset value; STAT reads 0x00 for all ports; obf_no=3'b111.
// - Write CTRL1=0x01, then DATA1=0xA5 -> pout_o[15:8]=0xA5 and poe_o[15:8]=0xFF one cycle after ack.
// - CTRL0=0x06, pins 0x3C, pulse stb_ni[0] low:
//   - ibf_o[0]=1 and irq_o=1 within 4 clocks.
//   - DATA0 read =0x3C, then ibf_o[0]=0 and irq_o=0.
// - Input overrun: a second strobe before the read with pins 0x55 -> DATA read =0x3C; STAT bit7=1;
//   a second STAT read gives bit7=0.
// - CTRL2=0x07, write DATA2=0x81 -> obf_no[2]=0. Pulse ack_ni[2] -> obf_no[2]=1, irq_o=1.
//   Write DATA2 -> irq_o=0.
// - Back-to-back stb_i held high -> ack_o toggles 1,0,1 and never stays high for 2 cycles;
//   adr=7 with NPORTS=3 reads 0.

Source files
------------

// File: rtl/ppi_wb_hs.sv
// ppi_wb_hs: Wishbone parallel port interface with 8255-style strobed/acknowledged handshakes
module ppi_wb_hs #(
  parameter int NPORTS = 3,
  parameter int DW = 8,
  localparam int AW = $clog2(2*NPORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AW-1:0]        adr_i,
  input  logic [DW-1:0]        dat_i,
  output logic [DW-1:0]        dat_o,
  input  logic                 we_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  output logic                 ack_o,
  output logic                 irq_o,
  input  logic [NPORTS*DW-1:0] pin_i,
  output logic [NPORTS*DW-1:0] pout_o,
  output logic [NPORTS*DW-1:0] poe_o,
  input  logic [NPORTS-1:0]    stb_ni,
  output logic [NPORTS-1:0]    ibf_o,
  output logic [NPORTS-1:0]    obf_no,
  input  logic [NPORTS-1:0]    ack_ni
);
  logic req;
  logic [DW-1:0] rdv;
  logic [NPORTS-1:0] intr;
  logic [NPORTS-1:0][DW-1:0] dv, sv;
  // masking with ack_o keeps every access to a single-cycle ack, even with stb_i held
  assign req = cyc_i & stb_i & ~ack_o;
  always_comb begin
    rdv = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (adr_i == AW'(2*i)) rdv = dv[i];
      if (adr_i == AW'(2*i+1)) rdv = sv[i];
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ack_o <= 1'b0;
      dat_o <= '0;
      irq_o <= 1'b0;
    end else begin
      ack_o <= req;
      dat_o <= (req & ~we_i) ? rdv : '0;
      irq_o <= |intr;
    end
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [2:0] ctrl, ss, as;
    logic [DW-1:0] lat, p1, p2;
    logic ibf, obf, ovr, sticky;
    logic wr_d, wr_c, rd_d, rd_c, stb_f, ack_f, hs_in, hs_out;
    assign wr_d = req & we_i & (adr_i == AW'(2*p));
    assign wr_c = req & we_i & (adr_i == AW'(2*p+1));
    assign rd_d = req & ~we_i & (adr_i == AW'(2*p));
    assign rd_c = req & ~we_i & (adr_i == AW'(2*p+1));
    // ss/as[1] is the synchronised level, [2] its previous value
    assign stb_f = ss[2] & ~ss[1];
    assign ack_f = as[2] & ~as[1];
    assign hs_in = ctrl[1] & ~ctrl[0];
    assign hs_out = ctrl[1] & ctrl[0];
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        ctrl <= '0;
        lat <= '0;
        p1 <= '0;
        p2 <= '0;
        ss <= '1;
        as <= '1;
        ibf <= 1'b0;
        obf <= 1'b0;
        ovr <= 1'b0;
        sticky <= 1'b0;
      end else begin
        p1 <= pin_i[p*DW +: DW];
        p2 <= p1;
        ss <= {ss[1:0], stb_ni[p]};
        as <= {as[1:0], ack_ni[p]};
        if (wr_c) begin
          ctrl <= dat_i[2:0];
          lat <= '0;
          ibf <= 1'b0;
          obf <= 1'b0;
          ovr <= 1'b0;
          sticky <= 1'b0;
        end else begin
          if (rd_c) ovr <= 1'b0;
          // a read coinciding with a strobe frees the buffer for the new data
          if (hs_in && stb_f) begin
            if (ibf & ~rd_d) ovr <= 1'b1;
            else begin
              lat <= p2;
              ibf <= 1'b1;
            end
          end else if (hs_in && rd_d) ibf <= 1'b0;
          if (ctrl[0] && wr_d) begin
            lat <= dat_i;
            obf <= ctrl[1];
            sticky <= sticky & ~ctrl[1];
          end else if (hs_out && ack_f) begin
            obf <= 1'b0;
            sticky <= 1'b1;
          end
        end
      end
    assign intr[p] = ctrl[2] & (hs_in ? ibf : hs_out & sticky);
    assign dv[p] = (ctrl[0] | ctrl[1]) ? lat : p2;
    assign sv[p] = DW'({ovr, intr[p], obf, ibf, 1'b0, ctrl});
    assign pout_o[p*DW +: DW] = ctrl[0] ? lat : '0;
    assign poe_o[p*DW +: DW] = {DW{ctrl[0]}};
    assign ibf_o[p] = ibf;
    assign obf_no[p] = ~obf;
  end
endmodule
